muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/muldiv_unit_if.sv | 22 ++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the multiply/divide unit: datapath width,
// M-extension funct3 encodings and the iterative engine's state encoding.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } muldiv_state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between an issuing pipeline and muldiv_unit.
interface muldiv_unit_if #(parameter int XLEN = riscv_pkg::XLEN);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      dest_addr;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      result_addr;
    logic            write_enable;

    modport master (
        output start, funct3, operand_a, operand_b, dest_addr,
        input  busy, done, result, result_addr, write_enable
    );
    modport slave (
        input  start, funct3, operand_a, operand_b, dest_addr,
        output busy, done, result, result_addr, write_enable
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle on operand magnitudes in a
// single shared 64-bit accumulator, sign fix-up in DONE, fixed 33-cycle latency.
module muldiv_unit #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      dest_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_addr,
    output logic            write_enable
);
    import riscv_pkg::*;

    localparam int CW = $clog2(XLEN);

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] a_q, a_d;
    logic            neg_q, neg_d;
    logic            bz_q, bz_d;
    logic [4:0]      dest_q, dest_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] res_q;
    logic [4:0]      raddr_q;

    // Request decode: which operands are signed and what sign the result takes
    muldiv_op_e      req_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    assign req_op = muldiv_op_e'(funct3);
    assign a_neg  = (req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && operand_a[XLEN-1];
    assign b_neg  = (req_op inside {OP_MULH, OP_DIV, OP_REM}) && operand_b[XLEN-1];
    assign a_mag  = a_neg ? -operand_a : operand_a;
    assign b_mag  = b_neg ? -operand_b : operand_b;

    logic            is_div;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_s;
    logic            rem_ge;
    logic [XLEN-1:0] rem_sub;
    logic [2*XLEN-1:0] step;
    assign is_div  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
    assign rem_s   = acc_q[2*XLEN-1:XLEN-1];
    assign rem_ge  = rem_s >= {1'b0, b_q};
    assign rem_sub = rem_s[XLEN-1:0] - b_q;

    // Multiply shifts right adding into the top half; divide shifts left,
    // quotient bits entering at the bottom, remainder growing in the top half.
    always_comb begin
        step = '0;
        if (is_div)
            step = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                          : {rem_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            step = {mul_sum, acc_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fin;
    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = acc_q[XLEN-1:0];
    assign rem  = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fin = '0;
        case (op_q)
            OP_MUL:                        fin = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fin = bz_q ? '1  : (neg_q ? -quo : quo);
            OP_REM, OP_REMU:               fin = bz_q ? a_q : (neg_q ? -rem : rem);
            default:                       fin = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        b_d     = b_q;
        a_d     = a_q;
        neg_d   = neg_q;
        bz_d    = bz_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1))
                    state_d = MD_DONE;
            end
            default: begin
                if (state_q == MD_DONE)
                    state_d = MD_IDLE;
                if (start) begin
                    state_d = MD_CALC;
                    op_d    = req_op;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    b_d     = b_mag;
                    a_d     = operand_a;
                    neg_d   = (req_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                    bz_d    = (operand_b == '0);
                    dest_d  = dest_addr;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            op_q    <= OP_MUL;
            acc_q   <= '0;
            b_q     <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            bz_q    <= 1'b0;
            dest_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            bz_q    <= bz_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            if (state_q == MD_DONE) begin
                res_q   <= fin;
                raddr_q <= dest_q;
            end
        end
    end

    assign busy         = (state_q == MD_CALC);
    assign done         = (state_q == MD_DONE);
    assign result       = done ? fin : res_q;
    assign result_addr  = done ? dest_q : raddr_q;
    assign write_enable = done && (result_addr != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases, ignored and
// back-to-back starts, reset abort, then randomized ops against a 64-bit model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (rst),
        .start        (bus.start),
        .funct3       (bus.funct3),
        .operand_a    (bus.operand_a),
        .operand_b    (bus.operand_b),
        .dest_addr    (bus.dest_addr),
        .busy         (bus.busy),
        .done         (bus.done),
        .result       (bus.result),
        .result_addr  (bus.result_addr),
        .write_enable (bus.write_enable)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  addr;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got=1 want=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", bus.result, mon_e.res);
                chk("result_addr", {27'b0, bus.result_addr}, {27'b0, mon_e.addr});
                chk("write_enable", {31'b0, bus.write_enable}, {31'b0, (mon_e.addr != 5'd0)});
                chk("latency", 32'(cyc - mon_e.cyc), 32'd33);
                chk("busy_in_done", {31'b0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start for the current cycle; returns one cycle later with start low
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        exp_t e;
        bus.start     = 1'b1;
        bus.funct3    = f;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_addr = d;
        e.res  = ref_md(f, a, b);
        e.addr = d;
        e.cyc  = cyc;
        sbq.push_back(e);
        tick(1);
        bus.start     = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.dest_addr = 5'($urandom);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  dir_f [10] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
    logic [31:0] dir_a [10] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] dir_b [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.funct3 = 3'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_addr = '0;
        rst = 1'b1;
        tick(3);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_we", {31'b0, bus.write_enable}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_addr", {27'b0, bus.result_addr}, 32'd0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 10; i++) begin
            issue(dir_f[i], dir_a[i], dir_b[i], 5'(i + 1));
            tick(33);
        end

        // Starts while busy must be dropped without disturbing the captured op
        d0 = done_cnt;
        issue(3'd5, 32'd100, 32'd7, 5'd9);
        tick(4);
        chk("busy_calc", {31'b0, bus.busy}, 32'd1);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.operand_a = 32'd1; bus.operand_b = 32'd1; bus.dest_addr = 5'd3;
        tick(1);
        bus.start = 1'b0;
        tick(14);
        bus.start = 1'b1; bus.funct3 = 3'd7; bus.operand_a = 32'd55; bus.operand_b = 32'd4; bus.dest_addr = 5'd4;
        tick(1);
        bus.start = 1'b0;
        tick(20);
        chk("ignored_done_count", 32'(done_cnt - d0), 32'd1);

        // Accept a new request in the DONE cycle, writing to x0
        issue(3'd0, 32'd1234, 32'd5678, 5'd12);
        tick(32);
        issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd0);
        tick(33);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) tick(32);
            else tick(32 + $urandom_range(1, 3));
        end
        tick(33);

        issue(3'd0, 32'd3, 32'd4, 5'd17);
        tick(40);
        chk("result_hold", bus.result, 32'd12);
        chk("addr_hold", {27'b0, bus.result_addr}, 32'd17);

        // Reset mid-calculation, with a competing start in the reset cycle
        d0 = done_cnt;
        issue(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd8);
        tick(9);
        rst = 1'b1;
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.dest_addr = 5'd6;
        tick(1);
        rst = 1'b0;
        bus.start = 1'b0;
        sbq.delete();
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_we", {31'b0, bus.write_enable}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_addr", {27'b0, bus.result_addr}, 32'd0);
        tick(30);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        for (int k = 0; k < 100 && sbq.size() != 0; k++) tick(1);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d want=0 pending", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
